sprite_cmd_sequencer: RTL and testbench

Upstream feeder for all sprite display components (Mario, Bowser, Fireball, ...). Accepts 32-bit sprite command words from the CPU over a memory-mapped slave and buffers them in a FIFO. Broadcasts each word on the shared `writedata` bus, stamped with the current back-buffer select bit. On CPU commit, waits for the next vertical-blank start, then issues one buffer-swap command (action 4'hF) per component ID, so every display flips tear-free in the same frame.

---
 rtl/sprite_cmd_pkg.sv | 46 ++++
 rtl/sync_cmd_fifo.sv | 73 +++++++
 rtl/sprite_cmd_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_sprite_cmd_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_cmd_pkg.sv
// Shared definitions for the sprite command bus: word fields, opcodes, sequencer states
// and status-word bit positions.
package sprite_cmd_pkg;

   localparam int unsigned COMP_W   = 6;
   localparam int unsigned COMP_MSB = 31;
   localparam int unsigned COMP_LSB = 26;
   localparam int unsigned CHLD_MSB = 25;
   localparam int unsigned CHLD_LSB = 21;
   localparam int unsigned ACT_MSB  = 20;
   localparam int unsigned ACT_LSB  = 17;
   localparam int unsigned TYPE_MSB = 16;
   localparam int unsigned TYPE_LSB = 14;
   localparam int unsigned BUF_BIT  = 13;
   localparam int unsigned DATA_MSB = 12;

   // Component 0 is reserved, so an all-zero word matches no display.
   localparam logic [31:0] NOP_WORD = 32'h0;

   localparam logic [3:0] ACTION_SWAP   = 4'hF;
   localparam logic [3:0] ACTION_UPDATE = 4'h1;

   localparam logic [2:0] TYPE_VIS  = 3'b001;
   localparam logic [2:0] TYPE_X    = 3'b010;
   localparam logic [2:0] TYPE_Y    = 3'b011;
   localparam logic [2:0] TYPE_ATTR = 3'b100;

   typedef enum logic [1:0] {DRAIN, FLUSH, WAIT_VBL, SWAP} seq_state_t;

   localparam int unsigned ST_FULL    = 16;
   localparam int unsigned ST_EMPTY   = 17;
   localparam int unsigned ST_PEND    = 18;
   localparam int unsigned ST_BUF     = 19;
   localparam int unsigned ST_OVF     = 20;
   localparam int unsigned ST_REJ_LSB = 24;

   function automatic logic [31:0] swap_word(input logic [COMP_W-1:0] id, input logic buf_sel);
      logic [31:0] w;
      w = NOP_WORD;
      w[COMP_MSB:COMP_LSB] = id;
      w[ACT_MSB:ACT_LSB]   = ACTION_SWAP;
      w[BUF_BIT]           = buf_sel;
      return w;
   endfunction

endpackage

// File: rtl/sync_cmd_fifo.sv
// Synchronous command FIFO with registered read data: a pop loads rd_data and raises
// rd_valid for exactly the following cycle. DEPTH must be a power of two.
module sync_cmd_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     rd_valid,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);
   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned CntW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;
   logic             do_wr, do_rd;

   assign full  = (count_q == CntW'(DEPTH));
   assign empty = (count_q == '0);
   // Fullness is judged on the registered count, so a pop never frees a slot for the same cycle.
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = do_rd;
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_rd) begin
         rd_ptr_d  = rd_ptr_q + AW'(1);
         rd_data_d = mem_q[rd_ptr_q];
      end
      if (do_wr && !do_rd)      count_d = count_q + CntW'(1);
      else if (do_rd && !do_wr) count_d = count_q - CntW'(1);
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign level    = count_q;

endmodule

// File: rtl/sprite_cmd_sequencer.sv
// Buffers CPU sprite commands and broadcasts them, then swaps every display's buffer at the
// next vblank. Define SEQ_CMD_FILTER_EN to drop component-0 and swap-action pushes.
module sprite_cmd_sequencer
   import sprite_cmd_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned MAX_ID     = 63,
   parameter int unsigned V_ACTIVE   = 480
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_write,
   input  logic        cpu_read,
   input  logic [1:0]  cpu_address,
   input  logic [31:0] cpu_writedata,
   output logic [31:0] cpu_readdata,
   input  logic [9:0]  hcount,
   input  logic [9:0]  vcount,
   output logic [31:0] writedata,
   output logic        frame_swapped
);
   localparam int unsigned       LvlW    = $clog2(FIFO_DEPTH) + 1;
   localparam logic [COMP_W-1:0] MaxId   = COMP_W'(MAX_ID);
   localparam logic [9:0]        VActive = 10'(V_ACTIVE);

   seq_state_t        state_q, state_d;
   logic [LvlW-1:0]   flush_cnt_q, flush_cnt_d, level;
   logic [COMP_W-1:0] id_q, id_d;
   logic [31:0]       swap_q, swap_d, readdata_q, readdata_d, status, fifo_data, wd;
   logic [7:0]        rej_q, rej_d;
   logic              active_buf_q, active_buf_d, ovf_q, ovf_d;
   logic              blank_q, blank_d, vbl_start_q, vbl_start_d;
   logic              last_q, last_d, frame_swapped_q, frame_swapped_d;
   logic              push_req, commit, clr_ovf, reject, push, pop;
   logic              full, empty, fifo_valid;
   logic              unused_hcount;

   assign unused_hcount = ^hcount;

   assign push_req = cpu_write && (cpu_address == 2'd0);
   assign commit   = cpu_write && (cpu_address == 2'd1);
   assign clr_ovf  = cpu_write && (cpu_address == 2'd2);

`ifdef SEQ_CMD_FILTER_EN
   assign reject = (cpu_writedata[COMP_MSB:COMP_LSB] == '0) ||
                   (cpu_writedata[ACT_MSB:ACT_LSB] == ACTION_SWAP);
`else
   assign reject = 1'b0;
`endif

   assign push = push_req && !reject && !full;

   sync_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (push),
      .wr_data  (cpu_writedata),
      .rd_en    (pop),
      .rd_data  (fifo_data),
      .rd_valid (fifo_valid),
      .level    (level),
      .full     (full),
      .empty    (empty)
   );

   always_comb begin
      state_d      = state_q;
      flush_cnt_d  = flush_cnt_q;
      id_d         = id_q;
      active_buf_d = active_buf_q;
      swap_d       = NOP_WORD;
      last_d       = 1'b0;
      pop          = 1'b0;
      unique case (state_q)
         DRAIN: begin
            pop = !empty;
            if (commit) begin
               // Count only entries still queued after this cycle's pop.
               flush_cnt_d = level - LvlW'(pop);
               state_d     = FLUSH;
            end
         end
         FLUSH: begin
            if (flush_cnt_q == '0) begin
               state_d = WAIT_VBL;
            end else begin
               pop         = 1'b1;
               flush_cnt_d = flush_cnt_q - LvlW'(1);
               if (flush_cnt_q == LvlW'(1)) state_d = WAIT_VBL;
            end
         end
         WAIT_VBL: begin
            if (vbl_start_q) begin
               state_d = SWAP;
               id_d    = COMP_W'(1);
            end
         end
         SWAP: begin
            swap_d = swap_word(id_q, ~active_buf_q);
            if (id_q == MaxId) begin
               state_d      = DRAIN;
               active_buf_d = ~active_buf_q;
               last_d       = 1'b1;
            end else begin
               id_d = id_q + COMP_W'(1);
            end
         end
      endcase
   end

   always_comb begin
      // Edge-detect so a blank already under way when WAIT_VBL is entered is ignored.
      blank_d         = (vcount >= VActive);
      vbl_start_d     = blank_d && !blank_q;
      frame_swapped_d = last_q;

      ovf_d = ovf_q;
      if (clr_ovf)                          ovf_d = 1'b0;
      else if (push_req && !reject && full) ovf_d = 1'b1;

      rej_d = rej_q;
`ifdef SEQ_CMD_FILTER_EN
      if (clr_ovf)                                    rej_d = '0;
      else if (push_req && reject && rej_q != 8'hFF) rej_d = rej_q + 8'd1;
`else
      rej_d = '0;
`endif

      status                        = '0;
      status[15:0]                  = 16'(level);
      status[ST_FULL]               = full;
      status[ST_EMPTY]              = empty;
      status[ST_PEND]               = (state_q != DRAIN);
      status[ST_BUF]                = active_buf_q;
      status[ST_OVF]                = ovf_q;
      status[ST_REJ_LSB+7:ST_REJ_LSB] = rej_q;
      readdata_d = cpu_read ? status : readdata_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= DRAIN;
         flush_cnt_q     <= '0;
         id_q            <= '0;
         active_buf_q    <= 1'b0;
         swap_q          <= NOP_WORD;
         last_q          <= 1'b0;
         frame_swapped_q <= 1'b0;
         blank_q         <= 1'b0;
         vbl_start_q     <= 1'b0;
         ovf_q           <= 1'b0;
         rej_q           <= '0;
         readdata_q      <= '0;
      end else begin
         state_q         <= state_d;
         flush_cnt_q     <= flush_cnt_d;
         id_q            <= id_d;
         active_buf_q    <= active_buf_d;
         swap_q          <= swap_d;
         last_q          <= last_d;
         frame_swapped_q <= frame_swapped_d;
         blank_q         <= blank_d;
         vbl_start_q     <= vbl_start_d;
         ovf_q           <= ovf_d;
         rej_q           <= rej_d;
         readdata_q      <= readdata_d;
      end
   end

   // FIFO words and swap words never overlap: nothing is popped in WAIT_VBL or SWAP.
   always_comb begin
      wd = swap_q;
      if (fifo_valid) begin
         wd          = fifo_data;
         wd[BUF_BIT] = ~active_buf_q;
      end
   end

   assign writedata     = wd;
   assign frame_swapped = frame_swapped_q;
   assign cpu_readdata  = readdata_q;

endmodule

// File: tb/tb_sprite_cmd_sequencer.sv
// Directed bench for sprite_cmd_sequencer: queue-based reference model checked every cycle,
// plus literal expectations. SEQ_CMD_FILTER_EN selects the filtered-push expectations.
module tb_sprite_cmd_sequencer;
   localparam int DEPTH = 16;
   localparam int MAXID = 63;
   localparam int VACT  = 480;
   localparam int M_DRAIN = 0, M_FLUSH = 1, M_WAIT = 2, M_SWAP = 3;

   logic        clk = 1'b0;
   logic        reset, cpu_write, cpu_read;
   logic [1:0]  cpu_address;
   logic [31:0] cpu_writedata, cpu_readdata, writedata;
   logic [9:0]  hcount, vcount;
   logic        frame_swapped;

   int errors = 0;
   int checks = 0;
   int swap_seen = 0;
   int fs_count = 0;

   sprite_cmd_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .cpu_write     (cpu_write),
      .cpu_read      (cpu_read),
      .cpu_address   (cpu_address),
      .cpu_writedata (cpu_writedata),
      .cpu_readdata  (cpu_readdata),
      .hcount        (hcount),
      .vcount        (vcount),
      .writedata     (writedata),
      .frame_swapped (frame_swapped)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] stamp(input logic [31:0] w, input bit ab);
      logic [31:0] r;
      r     = w;
      r[13] = ~ab;
      return r;
   endfunction

   // Reference model: commands live in a queue; outputs appear one cycle after decision.
   logic [31:0] mq[$];
   int          mode, rem, sid, rej;
   bit          abuf, ovf, mblank, mvbl, mlast, armed = 0;
   logic [31:0] exp_wd = '0, exp_rd = '0;
   bit          exp_fs = 0;

   always @(posedge clk) begin : model
      logic [31:0] nwd, w;
      bit          full0, evt, in_blank, lastnow, rej_now;
      if (reset) begin
         mq.delete();
         mode = M_DRAIN; rem = 0; sid = 0; rej = 0;
         abuf = 0; ovf = 0; mblank = 0; mvbl = 0; mlast = 0;
         exp_wd = '0; exp_rd = '0; exp_fs = 0; armed = 1;
      end else begin
         full0 = (mq.size() == DEPTH);
         if (cpu_read)
            exp_rd = {8'(rej), 3'b000, ovf, abuf, (mode != M_DRAIN), (mq.size() == 0), full0,
                      16'(mq.size())};
         evt      = mvbl;
         in_blank = (vcount >= VACT);
         mvbl     = in_blank && !mblank;
         mblank   = in_blank;
         nwd      = '0;
         lastnow  = 0;
         case (mode)
            M_DRAIN: begin
               if (mq.size() > 0) nwd = stamp(mq.pop_front(), abuf);
               if (cpu_write && cpu_address == 2'd1) begin
                  rem  = mq.size();
                  mode = M_FLUSH;
               end
            end
            M_FLUSH: begin
               if (rem > 0) begin
                  nwd = stamp(mq.pop_front(), abuf);
                  rem--;
               end
               if (rem == 0) mode = M_WAIT;
            end
            M_WAIT: if (evt) begin mode = M_SWAP; sid = 1; end
            default: begin
               nwd = {6'(sid), 5'd0, 4'hF, 3'd0, ~abuf, 13'd0};
               if (sid == MAXID) begin
                  abuf = ~abuf; mode = M_DRAIN; lastnow = 1;
               end else sid++;
            end
         endcase
         if (cpu_write && cpu_address == 2'd0) begin
            w = cpu_writedata;
            rej_now = 0;
`ifdef SEQ_CMD_FILTER_EN
            rej_now = (w[31:26] == 6'd0) || (w[20:17] == 4'hF);
`endif
            if (rej_now) begin
               if (rej < 255) rej++;
            end else if (full0) ovf = 1;
            else mq.push_back(w);
         end
         if (cpu_write && cpu_address == 2'd2) begin
            ovf = 0; rej = 0;
         end
         exp_fs = mlast;
         mlast  = lastnow;
         exp_wd = nwd;
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         check("wd", writedata, exp_wd);
         check("fs", 32'(frame_swapped), 32'(exp_fs));
         check("rd", cpu_readdata, exp_rd);
         if (writedata[20:17] == 4'hF && writedata[31:26] != 6'd0) swap_seen++;
         if (frame_swapped) fs_count++;
      end
   end

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      cpu_write = 1'b1; cpu_address = a; cpu_writedata = d;
      @(negedge clk);
      cpu_write = 1'b0; cpu_writedata = '0;
   endtask

   task automatic rd(output logic [31:0] d);
      cpu_read = 1'b1;
      @(negedge clk);
      cpu_read = 1'b0;
      d = cpu_readdata;
   endtask

   task automatic wait_swap(input int id, input string nm);
      int n;
      n = 0;
      while (!(writedata[20:17] == 4'hF && writedata[31:26] == 6'(id)) && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 300) begin
         errors++;
         $display("FAIL %s: swap id %0d seen=0 required=1 within 300 cycles", nm, id);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] s;
      int          snap;
      reset = 1'b1; cpu_write = 0; cpu_read = 0; cpu_address = 0; cpu_writedata = 0;
      hcount = 0; vcount = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_wd", writedata, 32'h0);
      check("rst_fs", 32'(frame_swapped), 32'h0);
      rd(s);
      check("rst_status", s, 32'h0002_0000);

      // Single push: appears two cycles later, for one cycle, stamped bit13=1.
      wr(2'd0, 32'h2002_8064);
      check("lat_early", writedata, 32'h0);
      @(negedge clk);
      check("lat_word", writedata, 32'h2002_A064);
      @(negedge clk);
      check("lat_nop", writedata, 32'h0);

      // Hold in WAIT_VBL and overfill.
      wr(2'd1, 32'h0);
      for (int i = 0; i < 17; i++) wr(2'd0, {6'(i + 1), 5'd0, 4'h1, 3'd1, 1'b0, 13'(i)});
      rd(s);
      check("ovf_status", s, 32'h0015_0010);
      wr(2'd2, 32'h0);
      rd(s);
      check("ovf_clear", s, 32'h0005_0010);
      vcount = 10'd480;
      repeat (120) @(negedge clk);
      vcount = 10'd0;
      check("ovf_fs_count", 32'(fs_count), 32'd1);
      rd(s);
      check("ovf_after", s, 32'h000A_0000);

      // Push 3, commit, push 2: 3 issue, swap at vblank, then 2 with bit13=0.
      do_reset();
      wr(2'd0, 32'h2002_8001);
      wr(2'd0, 32'h2402_8002);
      wr(2'd0, 32'h2802_8003);
      wr(2'd1, 32'h0);
      wr(2'd0, 32'h1002_2005);
      wr(2'd0, 32'h1402_0006);
      repeat (10) @(negedge clk);
      rd(s);
      check("cm_status", s, 32'h0004_0002);
      vcount = 10'd480;
      wait_swap(1, "cm_first");
      check("cm_first_word", writedata, 32'h041E_2000);
      wait_swap(63, "cm_last");
      check("cm_last_word", writedata, 32'h FC1E_2000);
      @(negedge clk);
      check("cm_fs", 32'(frame_swapped), 32'h1);
      check("cm_q0", writedata, 32'h1002_0005);
      @(negedge clk);
      check("cm_q1", writedata, 32'h1402_0006);
      vcount = 10'd0;
      repeat (3) @(negedge clk);
      rd(s);
      check("cm_buf", s, 32'h000A_0000);

      // Commit during an ongoing blank: swap waits for the next 479->480 crossing.
      vcount = 10'd500;
      repeat (3) @(negedge clk);
      snap = swap_seen;
      wr(2'd1, 32'h0);
      repeat (20) @(negedge clk);
      rd(s);
      check("blank_pend", s, 32'h000E_0000);
      vcount = 10'd0;
      repeat (3) @(negedge clk);
      vcount = 10'd479;
      repeat (2) @(negedge clk);
      check("blank_noswap", 32'(swap_seen), 32'(snap));
      vcount = 10'd480;
      wait_swap(1, "blank_first");
      check("blank_first_word", writedata, 32'h041E_0000);
      wait_swap(63, "blank_last");
      repeat (4) @(negedge clk);
      vcount = 10'd0;

      // Reset in the middle of a swap.
      repeat (3) @(negedge clk);
      wr(2'd1, 32'h0);
      vcount = 10'd480;
      wait_swap(20, "rs_id20");
      reset = 1'b1;
      @(negedge clk);
      check("rs_nop", writedata, 32'h0);
      reset = 1'b0;
      snap = swap_seen;
      repeat (80) @(negedge clk);
      check("rs_noswap", 32'(swap_seen), 32'(snap));
      rd(s);
      check("rs_status", s, 32'h0002_0000);
      vcount = 10'd0;

      // Component-0 and swap-action pushes.
      wr(2'd0, 32'h0002_4001);
      wr(2'd0, 32'h0C1E_0002);
`ifdef SEQ_CMD_FILTER_EN
      check("flt_w0", writedata, 32'h0);
      @(negedge clk);
      check("flt_w1", writedata, 32'h0);
      rd(s);
      check("flt_rej", s, 32'h0202_0000);
      wr(2'd2, 32'h0);
      rd(s);
      check("flt_clr", s, 32'h0002_0000);
`else
      check("flt_w0", writedata, 32'h0002_6001);
      @(negedge clk);
      check("flt_w1", writedata, 32'h0C1E_2002);
      rd(s);
      check("flt_rej", s, 32'h0002_0000);
`endif
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
